result_writeback: RTL and testbench
===================================

# result_writeback

Write-back stage returning the accumulator/ALU result to processor storage. It is the store-side counterpart of the operand-2 source selection: it routes a result byte to one of three targets:

- output image bit
- bit RAM
- byte RAM

It holds one command in a single-entry buffer with valid/ready flow control. The byte RAM is written through a request/acknowledge handshake. The buffered command is exposed on a forwarding port so the operand fetch path can bypass a pending store.

## Interface

Parameters:
- ADDR_W, 8, address width shared by all three targets; narrower targets use the low bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wbValid  in  1  upstream command valid.
- wbReady  out  1  slot can accept a command this cycle.
- wbSel  in  2  target select: 0 output image bit, 1 bit RAM, 2 byte RAM, 3 discard.
- wbAddr  in  ADDR_W  target address.
- wbData  in  8  result byte; bit targets use wbData[0].
- outWrEn  out  1  output image write strobe.
- outWrAddr  out  ADDR_W  output image address.
- outWrData  out  1  output image data.
- bitWrEn  out  1  bit RAM write strobe.
- bitWrAddr  out  ADDR_W  bit RAM address.
- bitWrData  out  1  bit RAM data.
- byteWrReq  out  1  byte RAM write request.
- byteWrAck  in  1  byte RAM accepted the write.
- byteWrAddr  out  ADDR_W  byte RAM address.
- byteWrData  out  8  byte RAM data.
- fwdValid  out  1  a buffered command is present.
- fwdSel  out  2  buffered wbSel.
- fwdAddr  out  ADDR_W  buffered wbAddr.
- fwdData  out  8  buffered wbData.
- wrCount  out  8  count of committed writes, modulo 256.

## Operation

- State machine with two states:
  - EMPTY: no command buffered.
  - FULL: a command is held in sel/addr/data registers.
- Accept occurs when wbValid & wbReady at a rising edge. On accept, wbSel/wbAddr/wbData are captured and the state becomes (or stays) FULL.
- The held command completes in the FULL state as follows:
  - sel 0, 1 or 3: completes in the first FULL cycle.
  - sel 2: completes in the cycle where byteWrReq & byteWrAck.
- wbReady = EMPTY | (FULL & completing this cycle). This is a combinational path from byteWrAck.
  - Completion plus a simultaneous accept loads the new command and stays FULL, giving back-to-back issue.
  - Completion with no accept goes to EMPTY.
- Strobes are derived from the held registers while FULL:
  - outWrEn = FULL & sel==0.
  - bitWrEn = FULL & sel==1.
  - byteWrReq = FULL & sel==2.
  - outWrData and bitWrData = held data[0]. byteWrData = held data.
  - All three address outputs carry the held address.
- Each command with sel 0 or 1 produces exactly one strobe cycle.
- byteWrReq stays high, with address and data stable, until byteWrAck is sampled high. byteWrAck is ignored while byteWrReq is low.
- Discard (sel 3) occupies the slot for one cycle and asserts no strobe.
- fwdValid = FULL. The fwd* outputs mirror the held registers. Forwarding reflects the not-yet-committed store, including during the completion cycle.
- wrCount increments by 1 on each completing command with sel 0, 1 or 2. It wraps 255→0 and does not count discards.

## Timing

- Reset (asynchronous, while reset=0):
  - State EMPTY; held registers and wrCount cleared to 0.
  - All strobes, byteWrReq and fwdValid are 0. wbReady = 1.
- Latency from accept edge N:
  - Bit-target strobe in cycle N+1.
  - byteWrReq rises in cycle N+1 and completes in the first cycle from N+1 onward in which byteWrAck=1.
- Throughput: one bit/discard command per cycle sustained. Byte commands are limited by ack.
- Reset asserted mid-handshake: the pending byte write is dropped and byteWrReq falls immediately (asynchronously). No wrCount update.
- All outputs except wbReady are registered-state decodes, so no input-to-output path exists except byteWrAck→wbReady.

## Test plan

- Reset then idle: all strobes 0, wbReady=1, wrCount=0, fwdValid=0.
- Accept sel=1, addr=0x12, data=0x01 → bitWrEn=1 for exactly one cycle at N+1 with bitWrAddr=0x12 and bitWrData=1; wrCount=1. Then accept sel=0, addr=0x03, data=0xFE → outWrEn=1 one cycle with outWrData=0.
- Back-to-back stream of 4 bit commands with wbValid held high → 4 consecutive strobe cycles, wbReady stays 1, wrCount=4.
- Accept sel=2, addr=0x40, data=0xA5 with ack delayed 3 cycles → byteWrReq high for 4 cycles with addr/data stable; wbReady=0 for the first 3 of those cycles and 1 in the ack cycle; fwdValid=1 with fwdData=0xA5 throughout.
- Discard (sel=3) → no strobe, slot free the next cycle, wrCount unchanged. 256 committed writes → wrCount wraps to 0.
- Drop reset during a byte wait → byteWrReq=0 immediately, state EMPTY, no write committed, wrCount=0.

Source files
------------

// File: rtl/result_writeback.sv
// result_writeback: single-entry write-back buffer that routes a result byte
// to the output image (bit), the bit RAM, or the byte RAM (req/ack handshake),
// and exposes the pending store on a forwarding port for operand bypass.
module result_writeback #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wbValid,
    output logic              wbReady,
    input  logic [1:0]        wbSel,
    input  logic [ADDR_W-1:0] wbAddr,
    input  logic [7:0]        wbData,
    output logic              outWrEn,
    output logic [ADDR_W-1:0] outWrAddr,
    output logic              outWrData,
    output logic              bitWrEn,
    output logic [ADDR_W-1:0] bitWrAddr,
    output logic              bitWrData,
    output logic              byteWrReq,
    input  logic              byteWrAck,
    output logic [ADDR_W-1:0] byteWrAddr,
    output logic [7:0]        byteWrData,
    output logic              fwdValid,
    output logic [1:0]        fwdSel,
    output logic [ADDR_W-1:0] fwdAddr,
    output logic [7:0]        fwdData,
    output logic [7:0]        wrCount
);

    localparam logic [1:0] SEL_OUT  = 2'd0;
    localparam logic [1:0] SEL_BIT  = 2'd1;
    localparam logic [1:0] SEL_BYTE = 2'd2;
    localparam logic [1:0] SEL_DISC = 2'd3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state;
    logic [1:0]        sel_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        data_q;
    logic [7:0]        wr_count_q;

    logic full;
    logic complete;
    logic accept;

    // Completion and acceptance: the only combinational input path is byteWrAck -> wbReady
    always_comb begin
        full     = (state == FULL);
        complete = full & ((sel_q != SEL_BYTE) | byteWrAck);
        wbReady  = ~full | complete;
        accept   = wbValid & wbReady;
    end

    // Slot FSM: accept loads the buffer (back-to-back on completion), completion frees it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= EMPTY;
            sel_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            wr_count_q <= '0;
        end else begin
            if (accept) begin
                state  <= FULL;
                sel_q  <= wbSel;
                addr_q <= wbAddr;
                data_q <= wbData;
            end else if (complete) begin
                state <= EMPTY;
            end
            // Discards free the slot but are not writes
            if (complete && (sel_q != SEL_DISC)) begin
                wr_count_q <= wr_count_q + 8'd1;
            end
        end
    end

    // Strobes and data are pure decodes of the held command
    always_comb begin
        outWrEn    = full & (sel_q == SEL_OUT);
        bitWrEn    = full & (sel_q == SEL_BIT);
        byteWrReq  = full & (sel_q == SEL_BYTE);
        outWrAddr  = addr_q;
        bitWrAddr  = addr_q;
        byteWrAddr = addr_q;
        outWrData  = data_q[0];
        bitWrData  = data_q[0];
        byteWrData = data_q;
        fwdValid   = full;
        fwdSel     = sel_q;
        fwdAddr    = addr_q;
        fwdData    = data_q;
        wrCount    = wr_count_q;
    end

endmodule

// File: tb/tb_result_writeback.sv
// Scoreboard bench for result_writeback: issued stores push their expected
// write onto a queue; a monitor pops and compares on every committed write.
module tb_result_writeback;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              wbValid;
    logic              wbReady;
    logic [1:0]        wbSel;
    logic [ADDR_W-1:0] wbAddr;
    logic [7:0]        wbData;
    logic              outWrEn;
    logic [ADDR_W-1:0] outWrAddr;
    logic              outWrData;
    logic              bitWrEn;
    logic [ADDR_W-1:0] bitWrAddr;
    logic              bitWrData;
    logic              byteWrReq;
    logic              byteWrAck;
    logic [ADDR_W-1:0] byteWrAddr;
    logic [7:0]        byteWrData;
    logic              fwdValid;
    logic [1:0]        fwdSel;
    logic [ADDR_W-1:0] fwdAddr;
    logic [7:0]        fwdData;
    logic [7:0]        wrCount;

    typedef struct packed {
        logic [1:0]        kind;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    result_writeback #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .wbValid(wbValid), .wbReady(wbReady), .wbSel(wbSel), .wbAddr(wbAddr), .wbData(wbData),
        .outWrEn(outWrEn), .outWrAddr(outWrAddr), .outWrData(outWrData),
        .bitWrEn(bitWrEn), .bitWrAddr(bitWrAddr), .bitWrData(bitWrData),
        .byteWrReq(byteWrReq), .byteWrAck(byteWrAck), .byteWrAddr(byteWrAddr), .byteWrData(byteWrData),
        .fwdValid(fwdValid), .fwdSel(fwdSel), .fwdAddr(fwdAddr), .fwdData(fwdData),
        .wrCount(wrCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Issue one command; returns #1 after the accept edge (cycle N+1)
    task automatic send(input logic [1:0] sel, input logic [7:0] addr, input logic [7:0] data,
                        input bit push);
        int waited;
        wr_t w;
        wbValid = 1'b1;
        wbSel   = sel;
        wbAddr  = addr;
        wbData  = data;
        waited  = 0;
        while (!wbReady && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!wbReady) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: wbReady=%0b expected 1", wbReady);
        end
        if (push && sel != 2'd3) begin
            w.kind = sel;
            w.addr = addr;
            w.data = (sel == 2'd2) ? data : {7'd0, data[0]};
            exp_q.push_back(w);
        end
        @(posedge clk); #1;
        wbValid = 1'b0;
    endtask

    // Monitor: every committed write must match the oldest expected one
    initial begin
        wr_t got;
        wr_t want;
        forever begin
            @(negedge clk);
            if (reset) begin
                got.kind = 2'd3;
                if (outWrEn) begin
                    got.kind = 2'd0; got.addr = outWrAddr; got.data = {7'd0, outWrData};
                end else if (bitWrEn) begin
                    got.kind = 2'd1; got.addr = bitWrAddr; got.data = {7'd0, bitWrData};
                end else if (byteWrReq && byteWrAck) begin
                    got.kind = 2'd2; got.addr = byteWrAddr; got.data = byteWrData;
                end
                if (got.kind != 2'd3) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_write: got 0x%0h expected none", got);
                    end else begin
                        want = exp_q.pop_front();
                        check("write", 32'(got), 32'(want));
                    end
                end
            end
        end
    end

    initial begin
        wbValid   = 1'b0;
        wbSel     = 2'd0;
        wbAddr    = '0;
        wbData    = '0;
        byteWrAck = 1'b0;
        reset     = 1'b0;
        #1;
        check("rst_outWrEn", outWrEn, 0);
        check("rst_bitWrEn", bitWrEn, 0);
        check("rst_byteWrReq", byteWrReq, 0);
        check("rst_fwdValid", fwdValid, 0);
        check("rst_wbReady", wbReady, 1);
        check("rst_wrCount", wrCount, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        check("idle_wbReady", wbReady, 1);
        check("idle_bitWrEn", bitWrEn, 0);

        // Single bit-RAM write, then output-image write
        send(2'd1, 8'h12, 8'h01, 1);
        check("bit_en", bitWrEn, 1);
        check("bit_addr", bitWrAddr, 32'h12);
        check("bit_data", bitWrData, 1);
        @(posedge clk); #1;
        check("bit_one_cycle", bitWrEn, 0);
        check("cnt_after_bit", wrCount, 1);
        send(2'd0, 8'h03, 8'hFE, 1);
        check("out_en", outWrEn, 1);
        check("out_data", outWrData, 0);
        @(posedge clk); #1;
        check("out_one_cycle", outWrEn, 0);
        check("cnt_after_out", wrCount, 2);

        // Back-to-back bit commands: ready must stay high throughout
        for (int i = 0; i < 4; i++) begin
            send(2'd1, 8'(8'h20 + i), 8'(i), 1);
            if (i > 0) check("b2b_ready", wbReady, 1);
            check("b2b_strobe", bitWrEn, 1);
        end
        @(posedge clk); #1;
        check("cnt_after_b2b", wrCount, 6);

        // Byte write with ack delayed three cycles
        send(2'd2, 8'h40, 8'hA5, 1);
        for (int k = 0; k < 3; k++) begin
            check("byte_req_wait", byteWrReq, 1);
            check("byte_addr_wait", byteWrAddr, 32'h40);
            check("byte_data_wait", byteWrData, 32'hA5);
            check("byte_ready_wait", wbReady, 0);
            check("byte_fwd_wait", {fwdValid, fwdData}, {1'b1, 8'hA5});
            @(posedge clk); #1;
        end
        byteWrAck = 1'b1;
        #1;
        check("byte_req_ack", byteWrReq, 1);
        check("byte_ready_ack", wbReady, 1);
        check("byte_fwd_ack", {fwdValid, fwdSel, fwdAddr, fwdData}, {1'b1, 2'd2, 8'h40, 8'hA5});
        @(posedge clk); #1;
        byteWrAck = 1'b0;
        check("byte_req_done", byteWrReq, 0);
        check("cnt_after_byte", wrCount, 7);

        // Discard: slot held one cycle, no strobe, no count
        send(2'd3, 8'h55, 8'hFF, 1);
        check("disc_fwd", {fwdValid, fwdSel}, {1'b1, 2'd3});
        check("disc_strobes", {outWrEn, bitWrEn, byteWrReq}, 0);
        check("disc_ready", wbReady, 1);
        @(posedge clk); #1;
        check("disc_free", fwdValid, 0);
        check("cnt_after_disc", wrCount, 7);

        // 249 more commits bring the count to 256, which wraps to 0
        for (int i = 0; i < 249; i++) begin
            send(2'd1, 8'(i), 8'(i), 1);
        end
        @(posedge clk); #1;
        check("cnt_wrap", wrCount, 0);

        // Reset asserted during a byte wait drops the write
        send(2'd2, 8'h77, 8'h3C, 0);
        check("pre_rst_req", byteWrReq, 1);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_req", byteWrReq, 0);
        check("rst_mid_fwd", fwdValid, 0);
        check("rst_mid_ready", wbReady, 1);
        check("rst_mid_cnt", wrCount, 0);
        @(posedge clk); #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_cnt", wrCount, 0);
        check("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute bound on run time
    initial begin
        #200000;
        $display("FAIL global_timeout: sim time exceeded limit");
        $fatal(1, "timeout");
    end

endmodule
